// File: rtl/user_str_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : user_str_arbiter
// Brief   : Round-robin burst arbiter merging four user output streams onto one
//           64-bit host-bound PCIe stream, configured via the user register bus.
//           Optional beat/backpressure counters built when STR_ARB_STATS_EN is
//           defined.
// Revision: 1.0 - initial release
// ============================================================================
module user_str_arbiter #(
    parameter logic [19:0] BASE_ADDR     = 20'h00100,
    parameter logic [7:0]  BURST_DEFAULT = 8'd16
) (
    input  logic          i_pcie_clk,
    input  logic          i_rst,
    input  logic [19:0]   i_user_addr,
    input  logic [31:0]   i_user_data,
    input  logic          i_user_wr_req,
    input  logic          i_user_rd_req,
    output logic [31:0]   o_user_data,
    output logic          o_user_rd_ack,
    input  logic [3:0]    i_req_valid,
    input  logic [255:0]  i_req_data,
    output logic [3:0]    o_req_ack,
    output logic          o_str_data_valid,
    output logic [63:0]   o_str_data,
    input  logic          i_str_ack
);

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_GRANT = 1'b1;

    localparam logic [2:0] c_OFF_EN     = 3'd0;
    localparam logic [2:0] c_OFF_BURST  = 3'd1;
    localparam logic [2:0] c_OFF_STATUS = 3'd2;
    localparam logic [2:0] c_OFF_BP     = 3'd7;

    logic [0:0]  r_state, w_state_nxt;
    logic [1:0]  r_g, w_g_nxt;
    logic [1:0]  r_last, w_last_nxt;
    logic [7:0]  r_beat_cnt, w_beat_cnt_nxt;
    logic [7:0]  r_burst_cur, w_burst_cur_nxt;
    logic [3:0]  r_en_mask;
    logic [7:0]  r_burst_len;
    logic        r_rd_ack;
    logic [31:0] r_rd_data;

    logic [3:0]  w_eligible;
    logic [1:0]  w_pick;
    logic        w_found;
    logic        w_granted;
    logic        w_cur_valid;
    logic        w_xfer;
    logic        w_backpressure;
    logic [7:0]  w_beat_inc;
    logic        w_hit;
    logic [2:0]  w_off;
    logic        w_wr;
    logic        w_rd;
    logic [31:0] w_rd_mux;
    logic [3:0][31:0] w_beat_ctr;
    logic [31:0] w_bp_ctr;
    logic        w_unused;

    assign w_unused = ^{i_user_data[31:8], i_user_addr[1:0]};

    assign w_granted      = (r_state == c_ST_GRANT);
    assign w_cur_valid    = i_req_valid[r_g];
    assign w_xfer         = w_granted & w_cur_valid & i_str_ack;
    assign w_backpressure = w_granted & w_cur_valid & ~i_str_ack;
    assign w_eligible     = i_req_valid & r_en_mask;
    assign w_beat_inc     = r_beat_cnt + 8'd1;

    // Rotating priority: first eligible requester after the last one served.
    always_comb begin
        w_pick  = r_last;
        w_found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (!w_found && w_eligible[r_last + 2'(k)]) begin
                w_pick  = r_last + 2'(k);
                w_found = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_pcie_clk) begin
        if (i_rst) begin
            r_state     <= c_ST_IDLE;
            r_g         <= 2'd0;
            r_last      <= 2'd3;
            r_beat_cnt  <= 8'd0;
            r_burst_cur <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_g         <= w_g_nxt;
            r_last      <= w_last_nxt;
            r_beat_cnt  <= w_beat_cnt_nxt;
            r_burst_cur <= w_burst_cur_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_g_nxt         = r_g;
        w_last_nxt      = r_last;
        w_beat_cnt_nxt  = r_beat_cnt;
        w_burst_cur_nxt = r_burst_cur;
        case (r_state)
            c_ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt     = c_ST_GRANT;
                    w_g_nxt         = w_pick;
                    w_beat_cnt_nxt  = 8'd0;
                    // Burst length is frozen per grant so mid-burst writes cannot truncate it.
                    w_burst_cur_nxt = r_burst_len;
                end
            end
            c_ST_GRANT: begin
                if (!w_cur_valid) begin
                    w_state_nxt = c_ST_IDLE;
                    w_last_nxt  = r_g;
                end else if (w_xfer) begin
                    w_beat_cnt_nxt = w_beat_inc;
                    if ((r_burst_cur != 8'd0) && (w_beat_inc == r_burst_cur)) begin
                        w_state_nxt = c_ST_IDLE;
                        w_last_nxt  = r_g;
                    end
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (combinational through the grant)
    // ------------------------------------------------------------------
    always_comb begin
        o_req_ack        = 4'b0000;
        o_str_data_valid = w_granted & w_cur_valid;
        case (r_g)
            2'd0:    o_str_data = i_req_data[63:0];
            2'd1:    o_str_data = i_req_data[127:64];
            2'd2:    o_str_data = i_req_data[191:128];
            default: o_str_data = i_req_data[255:192];
        endcase
        if (w_granted && i_str_ack) begin
            o_req_ack[r_g] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Register interface
    // ------------------------------------------------------------------
    assign w_hit = (i_user_addr[19:5] == BASE_ADDR[19:5]);
    assign w_off = i_user_addr[4:2];
    assign w_wr  = i_user_wr_req & w_hit;
    assign w_rd  = i_user_rd_req & w_hit;

    always_ff @(posedge i_pcie_clk) begin
        if (i_rst) begin
            r_en_mask   <= 4'hF;
            r_burst_len <= BURST_DEFAULT;
        end else if (w_wr) begin
            if (w_off == c_OFF_EN) begin
                r_en_mask <= i_user_data[3:0];
            end
            if (w_off == c_OFF_BURST) begin
                r_burst_len <= i_user_data[7:0];
            end
        end
    end

`ifdef STR_ARB_STATS_EN
    for (genvar n = 0; n < 4; n++) begin : g_beat_ctr
        logic [31:0] r_cnt;
        always_ff @(posedge i_pcie_clk) begin
            if (i_rst) begin
                r_cnt <= 32'd0;
            end else if (w_wr && (w_off == 3'(n + 3))) begin
                // Clear wins over a coincident transfer.
                r_cnt <= 32'd0;
            end else if (w_xfer && (r_g == 2'(n))) begin
                r_cnt <= r_cnt + 32'd1;
            end
        end
        assign w_beat_ctr[n] = r_cnt;
    end

    logic [31:0] r_bp_ctr;
    always_ff @(posedge i_pcie_clk) begin
        if (i_rst) begin
            r_bp_ctr <= 32'd0;
        end else if (w_wr && (w_off == c_OFF_BP)) begin
            r_bp_ctr <= 32'd0;
        end else if (w_backpressure) begin
            r_bp_ctr <= r_bp_ctr + 32'd1;
        end
    end
    assign w_bp_ctr = r_bp_ctr;
`else
    assign w_beat_ctr = '0;
    assign w_bp_ctr   = (w_backpressure & 1'b0) ? 32'd1 : 32'd0;
`endif

    always_comb begin
        w_rd_mux = 32'd0;
        case (w_off)
            c_OFF_EN:     w_rd_mux = {28'd0, r_en_mask};
            c_OFF_BURST:  w_rd_mux = {24'd0, r_burst_len};
            c_OFF_STATUS: w_rd_mux = {23'd0, r_state, 2'b00, r_g, 2'b00, r_last};
            3'd3:         w_rd_mux = w_beat_ctr[0];
            3'd4:         w_rd_mux = w_beat_ctr[1];
            3'd5:         w_rd_mux = w_beat_ctr[2];
            3'd6:         w_rd_mux = w_beat_ctr[3];
            default:      w_rd_mux = w_bp_ctr;
        endcase
    end

    always_ff @(posedge i_pcie_clk) begin
        if (i_rst) begin
            r_rd_ack  <= 1'b0;
            r_rd_data <= 32'd0;
        end else begin
            r_rd_ack <= w_rd;
            if (w_rd) begin
                r_rd_data <= w_rd_mux;
            end
        end
    end

    assign o_user_rd_ack = r_rd_ack;
    assign o_user_data   = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_user_str_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_user_str_arbiter
// Brief   : Self-checking bench for user_str_arbiter (register table, directed
//           scenarios and randomized traffic against a behavioural model).
// Revision: 1.0 - initial release
// ============================================================================
module tb_user_str_arbiter;

    localparam logic [19:0] BASE = 20'h00100;

    logic         clk = 1'b0;
    logic         rst;
    logic [19:0]  i_user_addr;
    logic [31:0]  i_user_data;
    logic         i_user_wr_req;
    logic         i_user_rd_req;
    logic [31:0]  o_user_data;
    logic         o_user_rd_ack;
    logic [3:0]   i_req_valid;
    logic [255:0] i_req_data;
    logic [3:0]   o_req_ack;
    logic         o_str_data_valid;
    logic [63:0]  o_str_data;
    logic         i_str_ack;

    always #5 clk = ~clk;

    user_str_arbiter dut (
        .i_pcie_clk       (clk),
        .i_rst            (rst),
        .i_user_addr      (i_user_addr),
        .i_user_data      (i_user_data),
        .i_user_wr_req    (i_user_wr_req),
        .i_user_rd_req    (i_user_rd_req),
        .o_user_data      (o_user_data),
        .o_user_rd_ack    (o_user_rd_ack),
        .i_req_valid      (i_req_valid),
        .i_req_data       (i_req_data),
        .o_req_ack        (o_req_ack),
        .o_str_data_valid (o_str_data_valid),
        .o_str_data       (o_str_data),
        .i_str_ack        (i_str_ack)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    bit          m_busy;
    int          m_g, m_last, m_cnt, m_blen;
    logic [3:0]  m_en;
    logic [7:0]  m_burst;
    bit          m_rdack;
    logic [31:0] m_rddata;
    logic [31:0] m_stat [4];
    logic [31:0] m_bp;

    task automatic m_reset();
        m_busy = 0; m_g = 0; m_last = 3; m_cnt = 0; m_blen = 0;
        m_en = 4'hF; m_burst = 8'd16; m_rdack = 0; m_rddata = 0;
        for (int i = 0; i < 4; i++) m_stat[i] = 0;
        m_bp = 0;
    endtask

    function automatic logic [31:0] regval(input int off);
        case (off)
            0: return {28'd0, m_en};
            1: return {24'd0, m_burst};
            2: return (m_busy ? 32'h100 : 32'h0) | 32'(m_g * 16) | 32'(m_last);
`ifdef STR_ARB_STATS_EN
            3, 4, 5, 6: return m_stat[off - 3];
            7: return m_bp;
`endif
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_edge();
        bit hit, xfer;
        int off;
        logic [3:0] elig;
        hit = (i_user_addr[19:5] == BASE[19:5]);
        off = int'(i_user_addr[4:2]);
        if (rst) begin
            m_reset();
            return;
        end
        m_rdack = i_user_rd_req && hit;
        if (m_rdack) m_rddata = regval(off);
        xfer = m_busy && i_req_valid[m_g] && i_str_ack;
        if (xfer) m_stat[m_g] = m_stat[m_g] + 1;
        if (m_busy && i_req_valid[m_g] && !i_str_ack) m_bp = m_bp + 1;
        if (!m_busy) begin
            elig = i_req_valid & m_en;
            for (int k = 1; k <= 4; k++) begin
                int idx;
                idx = (m_last + k) % 4;
                if (elig[idx]) begin
                    m_g = idx; m_busy = 1; m_cnt = 0; m_blen = int'(m_burst);
                    break;
                end
            end
        end else if (!i_req_valid[m_g]) begin
            m_busy = 0; m_last = m_g;
        end else if (xfer) begin
            m_cnt++;
            if (m_blen != 0 && m_cnt == m_blen) begin
                m_busy = 0; m_last = m_g;
            end
        end
        if (i_user_wr_req && hit) begin
            case (off)
                0: m_en = i_user_data[3:0];
                1: m_burst = i_user_data[7:0];
                3, 4, 5, 6: m_stat[off - 3] = 0;
                7: m_bp = 0;
                default: ;
            endcase
        end
    endtask

    // observed combinational outputs of the most recent step
    bit obs_valid;
    int obs_gid;

    // Called just after a negedge with inputs already driven.
    task automatic step();
        bit ev;
        logic [3:0] ea;
        #1;
        ev = m_busy && i_req_valid[m_g];
        ea = (m_busy && i_str_ack) ? 4'(1 << m_g) : 4'd0;
        chk("str_valid", o_str_data_valid, ev);
        if (ev) chk("str_data", o_str_data, i_req_data[m_g*64 +: 64]);
        chk("req_ack", o_req_ack, ea);
        obs_valid = o_str_data_valid;
        obs_gid = -1;
        for (int i = 0; i < 4; i++) if (o_str_data_valid && o_req_ack[i]) obs_gid = i;
        @(posedge clk);
        model_edge();
        #1;
        chk("rd_ack", o_user_rd_ack, m_rdack);
        if (m_rdack) chk("rd_data", o_user_data, m_rddata);
        @(negedge clk);
    endtask

    task automatic rand_data();
        for (int i = 0; i < 8; i++) i_req_data[i*32 +: 32] = $urandom;
    endtask

    task automatic reg_wr(input logic [19:0] a, input logic [31:0] d);
        i_user_addr = a; i_user_data = d; i_user_wr_req = 1;
        step();
        i_user_wr_req = 0;
    endtask

    task automatic reg_rd(input string name, input logic [19:0] a, input logic [31:0] exp);
        i_user_addr = a; i_user_rd_req = 1;
        step();
        i_user_rd_req = 0;
        chk({name, "_ack"}, o_user_rd_ack, 1'b1);
        chk(name, o_user_data, exp);
    endtask

    task automatic do_reset();
        rst = 1;
        step();
        rst = 0;
    endtask

    typedef struct {
        bit          wr;
        bit          rd;
        logic [19:0] addr;
        logic [31:0] wdata;
        bit          exp_ack;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vt [13];

    initial begin
        int cnt, c0, c1, c2, c3;
        vt[0]  = '{0, 1, 20'h00100, 32'h0,        1, 32'hF};
        vt[1]  = '{0, 1, 20'h00104, 32'h0,        1, 32'd16};
        vt[2]  = '{0, 1, 20'h00108, 32'h0,        1, 32'h3};
        vt[3]  = '{0, 1, 20'h00200, 32'h0,        0, 32'h0};
        vt[4]  = '{1, 1, 20'h00104, 32'h5,        1, 32'd16};
        vt[5]  = '{0, 1, 20'h00104, 32'h0,        1, 32'h5};
        vt[6]  = '{1, 0, 20'h00108, 32'hFFFFFFFF, 0, 32'h0};
        vt[7]  = '{0, 1, 20'h00108, 32'h0,        1, 32'h3};
        vt[8]  = '{0, 1, 20'h0011C, 32'h0,        1, 32'h0};
        vt[9]  = '{1, 1, 20'h00100, 32'hA,        1, 32'hF};
        vt[10] = '{0, 1, 20'h00100, 32'h0,        1, 32'hA};
        vt[11] = '{0, 1, 20'h10100, 32'h0,        0, 32'h0};
        vt[12] = '{1, 1, 20'h00104, 32'h10,       1, 32'h5};

        rst = 1; i_user_addr = 0; i_user_data = 0; i_user_wr_req = 0; i_user_rd_req = 0;
        i_req_valid = 0; i_req_data = '0; i_str_ack = 0;
        @(posedge clk);
        m_reset();
        @(negedge clk);
        chk("rst_str_valid", o_str_data_valid, 1'b0);
        chk("rst_req_ack", o_req_ack, 4'd0);
        chk("rst_rd_ack", o_user_rd_ack, 1'b0);
        chk("rst_user_data", o_user_data, 32'd0);
        rst = 0;

        // ---- register table ----
        for (int i = 0; i < 13; i++) begin
            i_user_addr = vt[i].addr; i_user_data = vt[i].wdata;
            i_user_wr_req = vt[i].wr; i_user_rd_req = vt[i].rd;
            step();
            chk("tbl_ack", o_user_rd_ack, vt[i].exp_ack);
            if (vt[i].exp_ack) chk("tbl_data", o_user_data, vt[i].exp_data);
        end
        i_user_wr_req = 0; i_user_rd_req = 0;
        reg_wr(BASE, 32'hF);

        // ---- round robin 1,2,3,4,1 with burst 4 ----
        do_reset();
        reg_wr(BASE + 20'h4, 32'd4);
        i_req_valid = 4'hF; i_str_ack = 1;
        for (int c = 0; c < 25; c++) begin
            rand_data();
            step();
            chk("rr_grant", 64'(obs_gid), (c % 5 == 0) ? 64'(-1) : 64'((c / 5) % 4));
        end
        i_req_valid = 0;
        step(); step();

        // ---- unlimited burst on stream 3, then stream 4 preferred ----
        do_reset();
        reg_wr(BASE + 20'h4, 32'd0);
        i_req_valid = 4'b0100;
        cnt = 0;
        for (int c = 0; c < 11; c++) begin
            rand_data();
            step();
            if (obs_valid) cnt++;
        end
        chk("unl_beats", 64'(cnt), 64'd10);
        i_req_valid = 0; step();
        i_req_valid = 4'hF; step(); step();
        chk("next_pref4", o_req_ack, 4'b1000);
        i_req_valid = 0; step(); step();

        // ---- en_mask change during stream 2 burst ----
        do_reset();
        c0 = 0; c1 = 0; c2 = 0; c3 = 0;
        i_req_valid = 4'b0010;
        for (int c = 0; c < 4; c++) begin
            step();
            if (obs_gid == 1) c1++;
        end
        reg_wr(BASE, 32'h5);
        if (obs_gid == 1) c1++;
        i_req_valid = 4'hF;
        for (int c = 0; c < 60; c++) begin
            rand_data();
            step();
            case (obs_gid)
                0: c0++; 1: c1++; 2: c2++; 3: c3++; default: ;
            endcase
        end
        chk("mask_s2_beats", 64'(c1), 64'd16);
        chk("mask_s4_beats", 64'(c3), 64'd0);
        chk("mask_s1_seen", 64'(c0 > 0), 64'd1);
        chk("mask_s3_seen", 64'(c2 > 0), 64'd1);
        i_req_valid = 0; step(); step();

        // ---- backpressure on stream 1 ----
        do_reset();
        i_req_valid = 4'b0001; i_str_ack = 0;
        step();
        for (int c = 0; c < 5; c++) begin
            step();
            chk("bp_no_ack", o_req_ack, 4'd0);
        end
        i_str_ack = 1;
        step(); step(); step();
        i_req_valid = 0; step();
`ifdef STR_ARB_STATS_EN
        reg_rd("bp_count", BASE + 20'h1C, 32'd5);
        reg_rd("s1_beats", BASE + 20'h0C, 32'd3);
`else
        reg_rd("bp_count", BASE + 20'h1C, 32'd0);
        reg_rd("s1_beats", BASE + 20'h0C, 32'd0);
`endif

        // ---- reset mid-burst ----
        i_req_valid = 4'hF;
        for (int c = 0; c < 4; c++) begin rand_data(); step(); end
        rst = 1; step(); rst = 0;
        #1;
        chk("rst_mid_valid", o_str_data_valid, 1'b0);
        i_req_valid = 0;
        reg_rd("rst_status", BASE + 20'h8, 32'h3);
        reg_rd("rst_en", BASE, 32'hF);

        // ---- randomized traffic ----
        for (int c = 0; c < 3000; c++) begin
            int r;
            for (int n = 0; n < 4; n++) if ($urandom_range(0, 3) == 0) i_req_valid[n] = ~i_req_valid[n];
            rand_data();
            i_str_ack = ($urandom_range(0, 3) != 0);
            i_user_wr_req = 0; i_user_rd_req = 0;
            r = $urandom_range(0, 19);
            i_user_addr = BASE + 20'(4 * $urandom_range(0, 7));
            i_user_data = $urandom_range(0, 15);
            if (r == 0) i_user_wr_req = 1;
            if (r == 1 || r == 2) i_user_rd_req = 1;
            if (r == 2 && $urandom_range(0, 1) == 1) i_user_addr = 20'h00300;
            if (r == 3) begin i_user_wr_req = 1; i_user_rd_req = 1; end
            rst = ($urandom_range(0, 499) == 0);
            step();
        end
        rst = 0; i_user_wr_req = 0; i_user_rd_req = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/user_str_arbiter.md
# user_str_arbiter

Round-robin scheduler that shares one host-bound 64-bit PCIe stream channel between four user-logic output streams. It sits between the user logic's four stream outputs and a single PCIe stream port, granting one requester at a time for a bounded burst. Arbitration is configured and observed through the 32-bit user register interface.

## Interface
Parameters:
- BASE_ADDR, 20'h00100, byte address of the 32-byte register window; must be 32-byte aligned.
- BURST_DEFAULT, 8'd16, reset value of the burst-length register.

Ports:
- i_pcie_clk  in  1  single clock for all logic.
- i_rst  in  1  synchronous, active-high reset.
- i_user_addr  in  20  register byte address.
- i_user_data  in  32  register write data.
- i_user_wr_req  in  1  one-cycle write strobe.
- i_user_rd_req  in  1  one-cycle read strobe.
- o_user_data  out  32  registered read data.
- o_user_rd_ack  out  1  read-data-valid pulse.
- i_req_valid  in  4  per-requester valid; bit n = stream n+1.
- i_req_data  in  256  requester data; stream n+1 occupies [64n+63:64n].
- o_req_ack  out  4  per-requester ack.
- o_str_data_valid  out  1  merged stream valid.
- o_str_data  out  64  merged stream data.
- i_str_ack  in  1  downstream ack.

## Operation
- Transfer rule on both sides: a beat moves when valid and ack are high in the same cycle.
- Datapath is combinational through the grant. o_str_data_valid = granted & i_req_valid[g]. o_str_data = slice g. o_req_ack[g] = granted & i_str_ack. All other ack bits are 0.
- FSM:
  - IDLE: form eligible = i_req_valid & en_mask. If nonzero, pick the first set bit searching from last+1 modulo 4, load g, clear beat_cnt, go to GRANT.
  - GRANT: beat_cnt increments per transfer. Set last = g and return to IDLE when either:
    - a transfer completes with beat_cnt+1 == burst_len (burst_len ≠ 0), or
    - i_req_valid[g] is low at a clock edge.
  - burst_len 0 means unlimited: the grant is held until valid drops.
- Registers (offset = i_user_addr[4:2]; window hit when i_user_addr[19:5] == BASE_ADDR[19:5]):
  - 0x00 en_mask[3:0], RW, reset 4'hF.
  - 0x04 burst_len[7:0], RW, reset BURST_DEFAULT.
  - 0x08 status, RO: {23'b0, state, 2'b0, g[1:0], 2'b0, last[1:0]}.
  - 0x0C-0x1C: see Configuration.
- Writes to RO or unmapped offsets are ignored. Unmapped in-window reads return 0. Out-of-window reads get no ack.
- en_mask and burst_len changes take effect at the next IDLE arbitration; an in-progress burst is not truncated.

## Timing
- Reset values: o_user_data 0, o_user_rd_ack 0, state IDLE, last 3 (so stream 1 has first priority), all o_req_ack 0, o_str_data_valid 0.
- Arbitration latency: eligible request seen in IDLE at cycle t gives grant, and valid on the output, at t+1.
- Re-arbitration costs one IDLE cycle, so there is one bubble between bursts.
- Read: o_user_rd_ack pulses the cycle after i_user_rd_req, with o_user_data valid in the same cycle.
- Write: takes effect on the next edge.
- Simultaneous write and read of the same register: read returns the old value.
- Reset asserted mid-burst: FSM returns to IDLE at that edge and the output drops immediately. Any beat acked in that same cycle is considered transferred.

## Configuration
- STR_ARB_STATS_EN defined:
  - Four 32-bit wrapping beat counters at 0x0C, 0x10, 0x14, 0x18 (streams 1-4), incremented per transfer of the granted stream.
  - Writing any value clears the addressed counter. If the clear coincides with a transfer, the counter reads 0 afterwards.
  - 0x1C is a 32-bit count of cycles with o_str_data_valid high and i_str_ack low (backpressure). It is also cleared on write.
- STR_ARB_STATS_EN undefined: these offsets read 0 and the counters are not built.

## Test plan
- Reset, then all four valid continuously, i_str_ack=1, burst_len=4: grants run 1,2,3,4,1 with 4 beats each and one-cycle gaps. Data slices match the granted stream.
- Only stream 3 valid, burst_len=0, stream 3 sends 10 beats then drops valid: one grant lasting 10 beats. Next IDLE prefers stream 4.
- Write en_mask=4'b0101 during a stream-2 burst: stream 2 finishes its 16 beats. Thereafter only streams 1 and 3 alternate.
- Stream 1 granted, i_str_ack low for 5 cycles: o_req_ack[0] stays 0, beat_cnt holds, no data is lost. With STR_ARB_STATS_EN, 0x1C reads 5.
- Read 0x04 after reset: o_user_rd_ack one cycle later with data 16. Read with i_user_addr outside the window: no ack.
- Assert i_rst mid-burst: next cycle o_str_data_valid=0, status reads IDLE with last=3, en_mask reads 0xF.
